// File: rtl/cov_bin_monitor.sv
// cov_bin_monitor: passive cmd/adr bus coverage monitor.
// Keeps a saturating hit counter per {cmd,adr} bin, tracks how many bins
// have been hit, and queues the first hit of every bin (with its data) in
// a small FIFO drained through a valid/ready port.
module cov_bin_monitor #(
  parameter int CMD_W      = 4,
  parameter int ADR_W      = 4,
  parameter int DATA_W     = 4,
  parameter int CNT_W      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [CMD_W-1:0]       cmd,
  input  logic [ADR_W-1:0]       adr,
  input  logic [DATA_W-1:0]      data,
  input  logic                   clr,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [CMD_W-1:0]       evt_cmd,
  output logic [ADR_W-1:0]       evt_adr,
  output logic [DATA_W-1:0]      evt_data,
  output logic                   evt_overflow,
  output logic [CMD_W+ADR_W:0]   uniq_cnt,
  output logic                   all_hit,
  input  logic                   rd_en,
  input  logic [CMD_W-1:0]       rd_cmd,
  input  logic [ADR_W-1:0]       rd_adr,
  output logic                   rd_valid,
  output logic [CNT_W-1:0]       rd_count
);

  localparam int BW    = CMD_W + ADR_W;
  localparam int NBINS = 1 << BW;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int EW    = CMD_W + ADR_W + DATA_W;
  localparam int UW    = BW + 1;

  logic [CNT_W-1:0] bin_cnt  [NBINS];
  logic [EW-1:0]    fifo_mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [UW-1:0]    uniq_q;
  logic             all_hit_q;
  logic             ovf_q;
  logic             vld_p1;
  logic [CNT_W-1:0] rd_count_p1;

  logic [BW-1:0]    bin_idx_p0;
  logic [CNT_W-1:0] hit_cnt_p0;
  logic             clear_p0;
  logic             first_hit_p0;
  logic [AW:0]      fifo_cnt;
  logic             fifo_full;
  logic             pop;
  logic             push_ok;
  logic             drop;
  logic [UW-1:0]    uniq_nxt;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Stage p0: decode the current bus sample against the bin table.
  assign bin_idx_p0   = {cmd, adr};
  assign hit_cnt_p0   = bin_cnt[bin_idx_p0];
  assign clear_p0     = rst | clr;
  assign first_hit_p0 = in_valid && (hit_cnt_p0 == '0);

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign fifo_cnt  = wr_ptr - rd_ptr;
  assign fifo_full = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
  assign evt_valid = (wr_ptr != rd_ptr);
  assign pop       = evt_valid && evt_ready;
  assign push_ok   = first_hit_p0 && (!fifo_full || pop);
  assign drop      = first_hit_p0 && fifo_full && !pop;
  assign uniq_nxt  = uniq_q + UW'(1);

  // Stage p1: per-bin saturating hit counters; clear wins over a sample.
  always_ff @(posedge clk) begin
    if (clear_p0) begin
      for (int i = 0; i < NBINS; i++) bin_cnt[i] <= '0;
    end else if (in_valid) begin
      bin_cnt[bin_idx_p0] <= sat_inc(hit_cnt_p0);
    end
  end

  // Event FIFO storage; entries are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_ok && !clear_p0) fifo_mem[wr_ptr[AW-1:0]] <= {cmd, adr, data};
  end

  // Control state: FIFO pointers, unique count, sticky overflow, query port.
  always_ff @(posedge clk) begin
    if (clear_p0) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      uniq_q      <= '0;
      all_hit_q   <= 1'b0;
      ovf_q       <= 1'b0;
      vld_p1      <= 1'b0;
      rd_count_p1 <= '0;
    end else begin
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (drop)    ovf_q  <= 1'b1;
      if (first_hit_p0) begin
        uniq_q    <= uniq_nxt;
        all_hit_q <= (uniq_nxt == UW'(NBINS));
      end
      vld_p1 <= rd_en;
      if (rd_en) rd_count_p1 <= bin_cnt[{rd_cmd, rd_adr}];
    end
  end

  assign {evt_cmd, evt_adr, evt_data} = fifo_mem[rd_ptr[AW-1:0]];
  assign evt_overflow = ovf_q;
  assign uniq_cnt     = uniq_q;
  assign all_hit      = all_hit_q;
  assign rd_valid     = vld_p1;
  assign rd_count     = rd_count_p1;

endmodule

// File: tb/tb_cov_bin_monitor.sv
// Testbench for cov_bin_monitor: directed vector table, corner-case
// sequences and randomized traffic, all checked against a queue/array model.
module tb_cov_bin_monitor;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [3:0]  cmd, adr, data;
  logic        clr;
  logic        evt_valid;
  logic        evt_ready;
  logic [3:0]  evt_cmd, evt_adr, evt_data;
  logic        evt_overflow;
  logic [8:0]  uniq_cnt;
  logic        all_hit;
  logic        rd_en;
  logic [3:0]  rd_cmd, rd_adr;
  logic        rd_valid;
  logic [3:0]  rd_count;

  cov_bin_monitor #(.CMD_W(4), .ADR_W(4), .DATA_W(4), .CNT_W(4), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .cmd(cmd), .adr(adr), .data(data),
    .clr(clr), .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_cmd(evt_cmd),
    .evt_adr(evt_adr), .evt_data(evt_data), .evt_overflow(evt_overflow),
    .uniq_cnt(uniq_cnt), .all_hit(all_hit), .rd_en(rd_en), .rd_cmd(rd_cmd),
    .rd_adr(rd_adr), .rd_valid(rd_valid), .rd_count(rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: plain arrays and a queue of pending first-hit events.
  int          cnt_m [256];
  int          uniq_m;
  bit          ovf_m;
  logic [11:0] evq [$];
  bit          rdv_m;
  int          rdc_m;
  logic [11:0] got [$];

  typedef struct packed {
    logic        clr, iv;
    logic [3:0]  cmd, adr, data;
    logic        rdy, rde;
    logic [3:0]  rc, ra;
    logic        ev;
    logic [11:0] ehead;
    logic [8:0]  uq;
    logic        rv;
    logic [3:0]  rcnt;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic idle();
    rst = 0; clr = 0; in_valid = 0; evt_ready = 0; rd_en = 0;
  endtask

  // Advance the model by one clock from the current inputs, clock the DUT,
  // then compare every observable output with the model.
  task automatic step();
    int b;
    b = {cmd, adr};
    if (rst || clr) begin
      for (int i = 0; i < 256; i++) cnt_m[i] = 0;
      uniq_m = 0; ovf_m = 0; evq.delete(); rdv_m = 0; rdc_m = 0;
    end else begin
      rdv_m = rd_en;
      if (rd_en) rdc_m = cnt_m[{rd_cmd, rd_adr}];
      if (evt_ready && evq.size() > 0) void'(evq.pop_front());
      if (in_valid) begin
        if (cnt_m[b] == 0) begin
          uniq_m++;
          if (evq.size() < 8) evq.push_back({cmd, adr, data});
          else ovf_m = 1;
        end
        if (cnt_m[b] < 15) cnt_m[b]++;
      end
    end
    @(posedge clk); #1;
    chk("evt_valid", evt_valid, evq.size() != 0);
    if (evq.size() != 0) chk("evt_head", {evt_cmd, evt_adr, evt_data}, evq[0]);
    chk("uniq_cnt", uniq_cnt, uniq_m);
    chk("all_hit", all_hit, uniq_m == 256);
    chk("evt_overflow", evt_overflow, ovf_m);
    chk("rd_valid", rd_valid, rdv_m);
    chk("rd_count", rd_count, rdc_m);
  endtask

  task automatic do_reset();
    idle(); rst = 1; step(); rst = 0;
  endtask

  // Pop everything currently queued into 'got', bounded by a cycle budget.
  task automatic drain();
    got.delete();
    for (int i = 0; i < 20; i++) begin
      if (!evt_valid) break;
      got.push_back({evt_cmd, evt_adr, evt_data});
      evt_ready = 1; step();
    end
    evt_ready = 0;
    chk("drain_done", evt_valid, 1'b0);
  endtask

  initial begin
    idle(); cmd = 0; adr = 0; data = 0; rd_cmd = 0; rd_adr = 0;

    //             clr iv cmd adr dat rdy rde rc ra  ev  ehead          uq rv rcnt
    tbl[0] = '{1'b0,1'b1,4'd3,4'd5,4'd9,1'b0,1'b0,4'd0,4'd0,1'b1,12'h359,9'd1,1'b0,4'd0};
    tbl[1] = '{1'b0,1'b0,4'd0,4'd0,4'd0,1'b0,1'b1,4'd3,4'd5,1'b1,12'h359,9'd1,1'b1,4'd1};
    tbl[2] = '{1'b0,1'b1,4'd3,4'd5,4'd2,1'b1,1'b1,4'd3,4'd5,1'b0,12'h000,9'd1,1'b1,4'd1};
    tbl[3] = '{1'b0,1'b0,4'd0,4'd0,4'd0,1'b0,1'b1,4'd3,4'd5,1'b0,12'h000,9'd1,1'b1,4'd2};
    tbl[4] = '{1'b1,1'b1,4'd2,4'd2,4'd6,1'b0,1'b0,4'd0,4'd0,1'b0,12'h000,9'd0,1'b0,4'd0};
    tbl[5] = '{1'b0,1'b0,4'd0,4'd0,4'd0,1'b0,1'b1,4'd2,4'd2,1'b0,12'h000,9'd0,1'b1,4'd0};
    tbl[6] = '{1'b0,1'b0,4'd0,4'd0,4'd0,1'b0,1'b1,4'd3,4'd5,1'b0,12'h000,9'd0,1'b1,4'd0};

    do_reset();
    chk("reset_evt_valid", evt_valid, 1'b0);
    chk("reset_uniq", uniq_cnt, 9'd0);
    for (int i = 0; i < 7; i++) begin
      clr = tbl[i].clr; in_valid = tbl[i].iv; cmd = tbl[i].cmd; adr = tbl[i].adr;
      data = tbl[i].data; evt_ready = tbl[i].rdy; rd_en = tbl[i].rde;
      rd_cmd = tbl[i].rc; rd_adr = tbl[i].ra;
      step();
      chk($sformatf("tbl%0d_evt_valid", i), evt_valid, tbl[i].ev);
      if (tbl[i].ev) chk($sformatf("tbl%0d_head", i), {evt_cmd, evt_adr, evt_data}, tbl[i].ehead);
      chk($sformatf("tbl%0d_uniq", i), uniq_cnt, tbl[i].uq);
      chk($sformatf("tbl%0d_rd_valid", i), rd_valid, tbl[i].rv);
      chk($sformatf("tbl%0d_rd_count", i), rd_count, tbl[i].rcnt);
    end
    idle();

    // Saturation: 20 hits on one bin, a single event.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      in_valid = 1; cmd = 1; adr = 1; data = 7; step();
    end
    idle(); rd_en = 1; rd_cmd = 1; rd_adr = 1; step(); rd_en = 0;
    chk("sat_rd_count", rd_count, 4'd15);
    chk("sat_uniq", uniq_cnt, 9'd1);
    drain();
    chk("sat_events", got.size(), 1);

    // Overflow: 10 first hits with no consumer.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      in_valid = 1; cmd = 0; adr = 4'(k); data = 4'(k); step();
    end
    idle(); step();
    chk("ovf_flag", evt_overflow, 1'b1);
    chk("ovf_uniq", uniq_cnt, 9'd10);
    drain();
    chk("ovf_events", got.size(), 8);
    for (int k = 0; k < 8 && k < got.size(); k++)
      chk($sformatf("ovf_order%0d", k), got[k], {4'd0, 4'(k), 4'(k)});
    chk("ovf_sticky", evt_overflow, 1'b1);

    // Full FIFO with simultaneous pop and push.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      in_valid = 1; cmd = 1; adr = 4'(k); data = 4'(k); step();
    end
    in_valid = 1; cmd = 1; adr = 8; data = 8; evt_ready = 1; step();
    idle();
    chk("pp_no_ovf", evt_overflow, 1'b0);
    drain();
    chk("pp_events", got.size(), 8);
    if (got.size() == 8) begin
      chk("pp_head", got[0], 12'h111);
      chk("pp_tail", got[7], 12'h188);
    end

    // Reset in the middle of a drain.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1; cmd = 2; adr = 4'(k); data = 1; step();
    end
    idle(); evt_ready = 1; step();
    evt_ready = 1; rst = 1; step(); idle();
    chk("mid_rst_evt", evt_valid, 1'b0);
    chk("mid_rst_uniq", uniq_cnt, 9'd0);

    // Sweep all bins, then clear.
    do_reset();
    evt_ready = 1;
    for (int b = 0; b < 256; b++) begin
      in_valid = 1; {cmd, adr} = 8'(b); data = 4'(b); step();
      if (b == 254) chk("sweep_not_all", all_hit, 1'b0);
    end
    idle(); step();
    chk("sweep_uniq", uniq_cnt, 9'd256);
    chk("sweep_all_hit", all_hit, 1'b1);
    clr = 1; step(); clr = 0;
    chk("clr_uniq", uniq_cnt, 9'd0);
    chk("clr_all_hit", all_hit, 1'b0);
    chk("clr_evt", evt_valid, 1'b0);
    for (int b = 0; b < 256; b++) begin
      rd_en = 1; {rd_cmd, rd_adr} = 8'(b); step();
    end
    idle();

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 399) == 0);
      clr       = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      cmd       = 4'($urandom_range(0, 3));
      adr       = 4'($urandom_range(0, 15));
      data      = 4'($urandom);
      evt_ready = ($urandom_range(0, 2) == 0);
      rd_en     = $urandom_range(0, 1);
      rd_cmd    = 4'($urandom_range(0, 3));
      rd_adr    = 4'($urandom_range(0, 15));
      step();
    end
    idle(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cov_bin_monitor.md
Name: cov_bin_monitor

Overview:
- Parametrised hardware successor to the interface-level cmd/adr coverage sampler.
- Snoops a cmd/adr/data bus every qualified clock and keeps a saturating hit counter per (cmd,adr) bin.
- Tracks the unique-bin count and all-bins-hit status, and queues first-hit events in a FIFO with a valid/ready drain port.
- Sits beside the DUT slave port as a passive monitor; it never drives the bus.

Parameters:
- CMD_W, 4, width of cmd field.
- ADR_W, 4, width of adr field.
- DATA_W, 4, width of data field.
- CNT_W, 4, width of each per-bin saturating hit counter.
- FIFO_DEPTH, 8, first-hit event FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  sole clock, all state on posedge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  bus sample qualifier.
- cmd  in  CMD_W  bus command.
- adr  in  ADR_W  bus address.
- data  in  DATA_W  bus data.
- clr  in  1  synchronous clear of all coverage state (same effect as rst).
- evt_valid  out  1  first-hit event available.
- evt_ready  in  1  consumer accepts event.
- evt_cmd  out  CMD_W  event cmd.
- evt_adr  out  ADR_W  event adr.
- evt_data  out  DATA_W  data seen on first hit.
- evt_overflow  out  1  sticky: a first-hit event was dropped.
- uniq_cnt  out  CMD_W+ADR_W+1  number of bins hit at least once.
- all_hit  out  1  uniq_cnt equals 2^(CMD_W+ADR_W).
- rd_en  in  1  bin count query.
- rd_cmd  in  CMD_W  query cmd.
- rd_adr  in  ADR_W  query adr.
- rd_valid  out  1  query result valid.
- rd_count  out  CNT_W  queried bin count.

Behaviour:
- Bin index = {cmd,adr}; NBINS = 2^(CMD_W+ADR_W).
- rst or clr, sampled at posedge:
  - All bin counters, uniq_cnt, all_hit, evt_overflow, FIFO pointers and rd_valid go to 0.
  - evt_valid is 0 the following cycle.
  - rd_count resets to 0.
- Sample (in_valid=1, no clr/rst):
  - Bin counter increments by 1 the next cycle.
  - Counter saturates at 2^CNT_W-1 and never wraps.
- First hit (bin counter was 0):
  - uniq_cnt increments the same update cycle.
  - all_hit is registered and asserts the cycle uniq_cnt reaches NBINS.
  - Entry {cmd,adr,data} is pushed to the FIFO.
- FIFO full on a first hit:
  - Event is dropped and evt_overflow sets; it stays set until rst/clr.
  - Bin counter and uniq_cnt still update.
- Simultaneous push and pop on a full FIFO: the pop completes and the push is accepted; no overflow.
- Event port:
  - evt_valid = FIFO non-empty. The evt_* fields show the head entry.
  - Pop when evt_valid && evt_ready.
  - Fields hold stable while evt_valid=1 and evt_ready=0.
  - Latency: a first-hit sample at edge N gives evt_valid=1 after edge N+1 if the FIFO was empty (1-cycle latency).
- Query:
  - rd_en at edge N gives rd_valid=1 and rd_count after edge N+1, for one cycle per rd_en.
  - A query and a sample to the same bin in the same cycle return the pre-increment value.
- clr and in_valid in the same cycle: clr wins and the sample is discarded.
- clr and evt_ready in the same cycle: the FIFO is emptied and the pop is irrelevant.
- Reset mid-drain: the entry under evt_valid is lost, with no partial state.
- Repeat hits on an already-hit bin never generate events.

Test Plan:
- Reset, then sample cmd=3 adr=5 data=9 once -> after 1 cycle: evt_valid=1, evt_cmd=3, evt_adr=5, evt_data=9, uniq_cnt=1; query (3,5) returns rd_count=1.
- Sample bin (1,1) 20 times, CNT_W=4 -> rd_count=15 (saturated), uniq_cnt=1, exactly one event.
- evt_ready=0, issue 10 distinct first hits, FIFO_DEPTH=8 -> 8 events retained in order, evt_overflow=1, uniq_cnt=10.
- Sweep all 256 bins once -> uniq_cnt=256, all_hit=1; clr -> uniq_cnt=0, all_hit=0, evt_valid=0, all query counts 0.
- In the same cycle: clr=1, in_valid=1 on bin (2,2) -> rd_count(2,2)=0, uniq_cnt=0, no event.
- FIFO full, same cycle evt_ready=1 plus new first hit -> no overflow; occupancy stays 8, new entry at tail.
